// File: rtl/reg_bus_arbiter_if.sv
// Bundle of the two requester ports, the register-bank strobe bus and the busy flag.
// slave is the arbiter's view; master is the requesters' and bank's view.
interface reg_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              reg_read;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output reg_read, reg_write, reg_addr, reg_wdata, busy,
        input  reg_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  reg_read, reg_write, reg_addr, reg_wdata, busy,
        output reg_rdata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-port arbiter serialising fixed-latency byte accesses onto the register-bank bus.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is port 0 fixed priority.
module reg_bus_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    reg_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic              win_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              any_req;
    logic              grant1;
    logic              take;

    assign any_req = bus.m0_req | bus.m1_req;
    assign take    = (state_q == StIdle) && any_req;

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On contention the port not granted last time wins.
    assign grant1 = bus.m1_req & (~bus.m0_req | ~last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= grant1;
        end
    end
`else
    assign grant1 = bus.m1_req & ~bus.m0_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            win_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (take) begin
                win_q   <= grant1;
                we_q    <= grant1 ? bus.m1_we    : bus.m0_we;
                addr_q  <= grant1 ? bus.m1_addr  : bus.m0_addr;
                wdata_q <= grant1 ? bus.m1_wdata : bus.m0_wdata;
            end
            if (state_q == StResp && !we_q) begin
                if (win_q) rdata1_q <= bus.reg_rdata;
                else       rdata0_q <= bus.reg_rdata;
            end
        end
    end

    // Read data is forwarded from the bank during RESP so it arrives together with the ack.
    always_comb begin
        bus.reg_read  = 1'b0;
        bus.reg_write = 1'b0;
        bus.m0_ack    = 1'b0;
        bus.m1_ack    = 1'b0;
        bus.m0_rdata  = rdata0_q;
        bus.m1_rdata  = rdata1_q;
        bus.reg_addr  = addr_q;
        bus.reg_wdata = wdata_q;
        bus.busy      = (state_q != StIdle);
        if (state_q == StAccess) begin
            bus.reg_read  = ~we_q;
            bus.reg_write = we_q;
        end
        if (state_q == StResp) begin
            bus.m0_ack = ~win_q;
            bus.m1_ack = win_q;
            if (!we_q) begin
                if (win_q) bus.m1_rdata = bus.reg_rdata;
                else       bus.m0_rdata = bus.reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: per-cycle vector table plus hand-written corner sequences.
// Expected grant order follows REG_ARB_ROUND_ROBIN_EN.
module tb_reg_bus_arbiter;

    typedef struct packed {
        logic       req0;
        logic       we0;
        logic [5:0] addr0;
        logic [7:0] wd0;
        logic       req1;
        logic       we1;
        logic [5:0] addr1;
        logic [7:0] wd1;
        logic [7:0] rdata;
    } in_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic       ack0;
        logic       ack1;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic       busy;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    reg_bus_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    reg_bus_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r0, logic w0, logic [5:0] a0, logic [7:0] d0,
                                  logic r1, logic w1, logic [5:0] a1, logic [7:0] d1,
                                  logic [7:0] rd);
        in_t v;
        v = '{req0: r0, we0: w0, addr0: a0, wd0: d0, req1: r1, we1: w1, addr1: a1, wd1: d1,
              rdata: rd};
        return v;
    endfunction

    function automatic out_t mk_out(logic rd, logic wr, logic [5:0] a, logic [7:0] wd,
                                    logic k0, logic k1, logic [7:0] r0, logic [7:0] r1,
                                    logic b);
        out_t o;
        o = '{rd: rd, wr: wr, addr: a, wdata: wd, ack0: k0, ack1: k1, rd0: r0, rd1: r1,
              busy: b};
        return o;
    endfunction

    task automatic apply(input in_t v);
        bus.m0_req    = v.req0;
        bus.m0_we     = v.we0;
        bus.m0_addr   = v.addr0;
        bus.m0_wdata  = v.wd0;
        bus.m1_req    = v.req1;
        bus.m1_we     = v.we1;
        bus.m1_addr   = v.addr1;
        bus.m1_wdata  = v.wd1;
        bus.reg_rdata = v.rdata;
    endtask

    function automatic out_t sample();
        out_t o;
        o.rd    = bus.reg_read;
        o.wr    = bus.reg_write;
        o.addr  = bus.reg_addr;
        o.wdata = bus.reg_wdata;
        o.ack0  = bus.m0_ack;
        o.ack1  = bus.m1_ack;
        o.rd0   = bus.m0_rdata;
        o.rd1   = bus.m1_rdata;
        o.busy  = bus.busy;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    vec_t vecs[13];

    initial begin
        logic [8:0] rd_bits;
        logic [8:0] ack_bits;
        logic       stray;
        int         order[4];
        int         exp_order[4];
        int         n_grant;
        out_t       o;

        apply(mk_in(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00));

        // Write 0xA5 to 0x03 on port 0, read 0x08 on port 1, then a withdrawn write.
        vecs[0]  = '{mk_in(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h00,8'h00, 0,0,8'h00,8'h00, 0)};
        vecs[1]  = '{mk_in(1,1,6'h03,8'hA5, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h00,8'h00, 0,0,8'h00,8'h00, 0)};
        vecs[2]  = '{mk_in(1,1,6'h03,8'hA5, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,1,6'h03,8'hA5, 0,0,8'h00,8'h00, 1)};
        vecs[3]  = '{mk_in(1,1,6'h03,8'hA5, 0,0,6'h00,8'h00, 8'h99),
                     mk_out(0,0,6'h03,8'hA5, 1,0,8'h00,8'h00, 1)};
        vecs[4]  = '{mk_in(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h03,8'hA5, 0,0,8'h00,8'h00, 0)};
        vecs[5]  = '{mk_in(0,0,6'h00,8'h00, 1,0,6'h08,8'h77, 8'h00),
                     mk_out(0,0,6'h03,8'hA5, 0,0,8'h00,8'h00, 0)};
        vecs[6]  = '{mk_in(0,0,6'h00,8'h00, 1,0,6'h08,8'h77, 8'h00),
                     mk_out(1,0,6'h08,8'h77, 0,0,8'h00,8'h00, 1)};
        vecs[7]  = '{mk_in(0,0,6'h00,8'h00, 1,0,6'h08,8'h77, 8'h3C),
                     mk_out(0,0,6'h08,8'h77, 0,1,8'h00,8'h3C, 1)};
        vecs[8]  = '{mk_in(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h08,8'h77, 0,0,8'h00,8'h3C, 0)};
        vecs[9]  = '{mk_in(1,1,6'h10,8'h5A, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h08,8'h77, 0,0,8'h00,8'h3C, 0)};
        vecs[10] = '{mk_in(0,1,6'h10,8'h5A, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,1,6'h10,8'h5A, 0,0,8'h00,8'h3C, 1)};
        vecs[11] = '{mk_in(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 8'hEE),
                     mk_out(0,0,6'h10,8'h5A, 1,0,8'h00,8'h3C, 1)};
        vecs[12] = '{mk_in(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 8'h00),
                     mk_out(0,0,6'h10,8'h5A, 0,0,8'h00,8'h3C, 0)};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1 apply(vecs[i].in);
            #3 check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
        end

        // Back-to-back port 0 reads with req held: strobes 3 cycles apart, one per ack.
        rd_bits  = '0;
        ack_bits = '0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1 apply(mk_in(1, 0, 6'h05, 8'h00, 0, 0, 6'h00, 8'h00, 8'h42));
            #3;
            rd_bits[c]  = bus.reg_read;
            ack_bits[c] = bus.m0_ack;
        end
        @(posedge clk);
        #1 apply(mk_in(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00));
        check("b2b_strobes", 64'(rd_bits), 64'(9'b010010010));
        check("b2b_acks", 64'(ack_bits), 64'(9'b100100100));
        #3 check("b2b_rdata", 64'(bus.m0_rdata), 64'(8'h42));

        // Reset during ACCESS: strobe and busy drop at once, no ack after release.
        @(posedge clk);
        #1 apply(mk_in(1, 1, 6'h20, 8'h11, 0, 0, 6'h00, 8'h00, 8'h00));
        @(posedge clk);
        #1;
        #3 check("rst_pre_strobe", 64'({bus.reg_write, bus.busy}), 64'(2'b11));
        #1 rst = 1'b1;
        #1;
        o = sample();
        check("rst_async", 64'(o), 64'(mk_out(0,0,6'h00,8'h00, 0,0,8'h00,8'h00, 0)));
        apply(mk_in(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00));
        @(posedge clk);
        #1 rst = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #4;
            stray |= bus.m0_ack | bus.m1_ack | bus.reg_read | bus.reg_write | bus.busy;
        end
        check("rst_no_ack", 64'(stray), 64'(1'b0));

        // Contention: both ports keep requesting; record the ack order.
`ifdef REG_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        order   = '{9, 9, 9, 9};
        n_grant = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 apply(mk_in(1, 0, 6'h01, 8'h00, 1, 0, 6'h02, 8'h00, 8'h00));
            #3;
            if (bus.m0_ack || bus.m1_ack) begin
                if (n_grant < 4) order[n_grant] = (bus.m0_ack && bus.m1_ack) ? 2 :
                                                  (bus.m1_ack ? 1 : 0);
                n_grant++;
            end
        end
        @(posedge clk);
        #1 apply(mk_in(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 8'h00));
        check("grant_count", 64'(n_grant), 64'(4));
        for (int g = 0; g < 4; g++) begin
            check($sformatf("grant%0d", g), 64'(order[g]), 64'(exp_order[g]));
        end

        repeat (4) @(posedge clk);
        #4 check("final_idle", 64'(bus.busy), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
